// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the instruction cache
//   ICACHE_NSETS   default number of one-word frames
//   icache_state_t controller state (COMPARE lookup, FETCH fill)
//   icachef_t      byte-address decode {tag, idx, bytoff} for the default geometry
package cpu_types_pkg;
  localparam int ICACHE_NSETS = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
  typedef enum logic {COMPARE, FETCH} icache_state_t;
  typedef struct packed {
    logic [29-ICACHE_IDX_W:0] tag;
    logic [ICACHE_IDX_W-1:0]  idx;
    logic [1:0]               bytoff;
  } icachef_t;
endpackage

// File: rtl/icache_frames.sv
// icache_frames: valid/tag/data storage for a direct-mapped cache
//   CLK, nRST            clock, async active-low clear of all valid bits
//   wen/widx/wtag/wdata  single write port, sets the frame valid
//   ridx -> valid/tag/data  combinational read port
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data
);
  logic [NSETS-1:0] valids;
  logic [TAG_W-1:0] tags  [NSETS];
  logic [31:0]      datas [NSETS];

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) valids <= '0;
    else if (wen) valids[widx] <= 1'b1;

  // tag/data need no reset: a frame is only read through its valid bit
  always_ff @(posedge CLK)
    if (wen) begin
      tags[widx]  <= wtag;
      datas[widx] <= wdata;
    end

  assign valid = valids[ridx];
  assign tag   = tags[ridx];
  assign data  = datas[ridx];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-word fills
//   CLK, nRST              clock, async active-low reset
//   imemREN, imemaddr      fetch request from IF stage
//   ihit, imemload         hit flag and instruction word (0 unless ihit)
//   iREN, iaddr            fill request/word address to memory controller
//   iwait, iload           memory busy flag and fill data
//   hit_count, miss_count  saturating performance counters
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  icache_state_t    state, next_state;
  logic [29:0]      miss_word;
  logic             f_valid, fill, miss;
  logic [TAG_W-1:0] f_tag;
  logic [31:0]      f_data;
  logic             unused_bytoff;

  // byte offset never selects anything: misaligned fetches read the containing word
  assign unused_bytoff = ^imemaddr[1:0];

  icache_frames #(.NSETS(NSETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .wen   (fill),
    .widx  (miss_word[IDX_W-1:0]),
    .wtag  (miss_word[29:IDX_W]),
    .wdata (iload),
    .ridx  (imemaddr[IDX_W+1:2]),
    .valid (f_valid),
    .tag   (f_tag),
    .data  (f_data)
  );

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    fill       = 1'b0;
    miss       = 1'b0;
    if (state == COMPARE) begin
      ihit       = imemREN & f_valid & (f_tag == imemaddr[31:IDX_W+2]);
      imemload   = ihit ? f_data : '0;
      miss       = imemREN & ~ihit;
      next_state = miss ? FETCH : COMPARE;
    end else begin
      // fill always completes to the latched address, even if the fetch port redirected
      iREN       = 1'b1;
      iaddr      = {miss_word, 2'b00};
      fill       = ~iwait;
      next_state = iwait ? FETCH : COMPARE;
    end
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state      <= COMPARE;
      miss_word  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (miss) miss_word <= imemaddr[31:2];
      if (ihit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (miss && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed bench with a word-address cache model checked every cycle
module tb_icache_dm;
  localparam int NS = 16;

  logic        CLK, nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;
  int          tests, fails;

  icache_dm dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model: each frame remembers the full word address it holds; one fill outstanding at most
  logic        m_v  [NS];
  logic [29:0] m_wa [NS];
  logic [31:0] m_d  [NS];
  logic        busy;
  logic [31:0] pend, hc, mc;

  function automatic int slot(input logic [31:0] a);
    return int'(a[31:2]) % NS;
  endfunction

  function automatic logic m_hit();
    return !busy && imemREN && m_v[slot(imemaddr)] && m_wa[slot(imemaddr)] == imemaddr[31:2];
  endfunction

  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      busy <= 1'b0;
      pend <= '0;
      hc   <= '0;
      mc   <= '0;
      for (int i = 0; i < NS; i++) m_v[i] <= 1'b0;
    end else if (busy) begin
      if (!iwait) begin
        m_v[slot(pend)]  <= 1'b1;
        m_wa[slot(pend)] <= pend[31:2];
        m_d[slot(pend)]  <= iload;
        busy             <= 1'b0;
      end
    end else if (imemREN) begin
      if (m_hit()) hc <= (hc == 32'hFFFF_FFFF) ? hc : hc + 1;
      else begin
        busy <= 1'b1;
        pend <= imemaddr;
        mc   <= (mc == 32'hFFFF_FFFF) ? mc : mc + 1;
      end
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("m_ihit", {31'd0, ihit}, {31'd0, m_hit()});
    chk("m_imemload", imemload, m_hit() ? m_d[slot(imemaddr)] : 32'd0);
    chk("m_iREN", {31'd0, iREN}, {31'd0, busy});
    chk("m_iaddr", iaddr, busy ? {pend[31:2], 2'b00} : 32'd0);
    chk("m_hit_count", hit_count, hc);
    chk("m_miss_count", miss_count, mc);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // request addr, expect a miss, hold iwait for lat FETCH cycles, then deliver data
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int lat);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
    mid(); chk("miss_ihit", {31'd0, ihit}, 32'd0);
    tick();
    for (int i = 0; i < lat; i++) begin
      mid();
      chk("fetch_iREN", {31'd0, iREN}, 32'd1);
      chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
      tick();
    end
    iwait = 1'b0; iload = d;
    tick();
  endtask

  initial begin
    tests = 0; fails = 0;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    tick(); mid();
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_counts", hit_count | miss_count, 32'd0);
    tick(); nRST = 1'b1;

    fill(32'h0000_0004, 32'h2001_0005, 3);
    mid();
    chk("cold_ihit", {31'd0, ihit}, 32'd1);
    chk("cold_load", imemload, 32'h2001_0005);
    chk("cold_miss_count", miss_count, 32'd1);
    chk("model_mc", mc, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); mid();
      chk("hold_ihit", {31'd0, ihit}, 32'd1);
      chk("hold_iREN", {31'd0, iREN}, 32'd0);
    end
    tick(); imemREN = 1'b0; mid();
    chk("hold_hit_count", hit_count, 32'd5);
    chk("model_hc", hc, 32'd5);
    chk("renlow_ihit", {31'd0, ihit}, 32'd0);

    tick(); imemREN = 1'b1; imemaddr = 32'h0000_0007; mid();
    chk("bytoff_ihit", {31'd0, ihit}, 32'd1);
    chk("bytoff_load", imemload, 32'h2001_0005);

    tick();
    fill(32'h0000_0044, 32'hDEAD_BEEF, 1);
    mid();
    chk("evict_load", imemload, 32'hDEAD_BEEF);
    tick(); imemaddr = 32'h0000_0004; iwait = 1'b1; mid();
    chk("evicted_ihit", {31'd0, ihit}, 32'd0);
    tick(); mid();
    chk("evict_iREN", {31'd0, iREN}, 32'd1);
    chk("evict_miss_count", miss_count, 32'd3);
    iwait = 1'b0; iload = 32'h2001_0005;
    tick(); mid();
    chk("refill_ihit", {31'd0, ihit}, 32'd1);

    tick(); imemaddr = 32'h0000_0100; iwait = 1'b1;
    tick(); imemaddr = 32'h0000_0204; mid();
    chk("redir_iaddr", iaddr, 32'h0000_0100);
    tick(); mid();
    chk("redir_iaddr2", iaddr, 32'h0000_0100);
    iwait = 1'b0; iload = 32'h1111_1111;
    tick(); mid();
    chk("redir_newmiss", {31'd0, ihit}, 32'd0);
    iload = 32'h2222_2222;
    tick(); mid();
    chk("redir_fetch2", iaddr, 32'h0000_0204);
    tick(); mid();
    chk("redir_load2", imemload, 32'h2222_2222);
    tick(); imemaddr = 32'h0000_0100; mid();
    chk("redir_old_hit", {31'd0, ihit}, 32'd1);
    chk("redir_old_load", imemload, 32'h1111_1111);
    chk("redir_miss_count", miss_count, 32'd5);

    tick(); imemaddr = 32'h0000_0300; iwait = 1'b1;
    tick(); mid();
    chk("pre_rst_iREN", {31'd0, iREN}, 32'd1);
    #1 nRST = 1'b0;
    #1 chk("async_iREN", {31'd0, iREN}, 32'd0);
    chk("async_iaddr", iaddr, 32'd0);
    tick(); nRST = 1'b1; mid();
    chk("post_rst_miss", {31'd0, ihit}, 32'd0);
    chk("post_rst_counts", hit_count | miss_count, 32'd0);
    tick(); iwait = 1'b0; iload = 32'h3333_3333;
    tick(); mid();
    chk("post_rst_hit", imemload, 32'h3333_3333);
    tick(); imemaddr = 32'h0000_0004; mid();
    chk("inval_miss", {31'd0, ihit}, 32'd0);
    tick(); iload = 32'h2001_0005;
    tick(); mid();
    chk("inval_refill", imemload, 32'h2001_0005);
    tick(); imemREN = 1'b0; mid();
    chk("idle_ihit", {31'd0, ihit}, 32'd0);
    chk("idle_hit_count", hit_count, 32'd2);
    chk("idle_miss_count", miss_count, 32'd2);
    tick(); imemaddr = 32'h0000_0044; mid();
    chk("idle_iREN", {31'd0, iREN}, 32'd0);
    chk("idle_hit_count2", hit_count, 32'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
